// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite responder: C_NUM_REGS byte-writable control registers plus one read-only status word.
// Write commits one cycle after the later AW/W handshake; reads answer one cycle after AR; one outstanding op per direction.
module axi4_lite_slave_regbank #(
  parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
  parameter int C_NUM_REGS              = 8
) (
  input  logic                                   S_AXI_LITE_ACLK,
  input  logic                                   S_AXI_LITE_ARESETN,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     S_AXI_LITE_AWADDR,
  input  logic [2:0]                             S_AXI_LITE_AWPROT,
  input  logic                                   S_AXI_LITE_AWVALID,
  output logic                                   S_AXI_LITE_AWREADY,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     S_AXI_LITE_WDATA,
  input  logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]   S_AXI_LITE_WSTRB,
  input  logic                                   S_AXI_LITE_WVALID,
  output logic                                   S_AXI_LITE_WREADY,
  output logic [1:0]                             S_AXI_LITE_BRESP,
  output logic                                   S_AXI_LITE_BVALID,
  input  logic                                   S_AXI_LITE_BREADY,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     S_AXI_LITE_ARADDR,
  input  logic [2:0]                             S_AXI_LITE_ARPROT,
  input  logic                                   S_AXI_LITE_ARVALID,
  output logic                                   S_AXI_LITE_ARREADY,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     S_AXI_LITE_RDATA,
  output logic [1:0]                             S_AXI_LITE_RRESP,
  output logic                                   S_AXI_LITE_RVALID,
  input  logic                                   S_AXI_LITE_RREADY,
  output logic [C_S_AXI_LITE_DATA_WIDTH*C_NUM_REGS-1:0] REG_OUT,
  output logic [C_NUM_REGS-1:0]                  REG_WR_PULSE,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     STATUS_IN
);

  localparam int DW   = C_S_AXI_LITE_DATA_WIDTH;
  localparam int NB   = DW / 8;
  localparam int IDXW = C_S_AXI_LITE_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  logic            active;
  logic [0:0]      w_state;
  logic [0:0]      r_state;
  logic            aw_have;
  logic            w_have;
  logic [IDXW-1:0] aw_idx;
  logic [DW-1:0]   w_data;
  logic [NB-1:0]   w_strb;
  logic [DW-1:0]   regs [C_NUM_REGS];

  logic            aw_hs;
  logic            w_hs;
  logic            ar_hs;
  logic            w_commit;
  logic            aw_is_rw;
  logic [IDXW-1:0] ar_idx;
  logic            ar_is_rw;
  logic            ar_is_status;
  logic [DW-1:0]   rd_mux;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_LITE_AWPROT, S_AXI_LITE_ARPROT,
                           S_AXI_LITE_AWADDR[1:0], S_AXI_LITE_ARADDR[1:0]};

  assign S_AXI_LITE_AWREADY = active && (w_state == W_IDLE) && !aw_have;
  assign S_AXI_LITE_WREADY  = active && (w_state == W_IDLE) && !w_have;
  assign S_AXI_LITE_ARREADY = active && (r_state == R_IDLE);

  assign aw_hs    = S_AXI_LITE_AWVALID && S_AXI_LITE_AWREADY;
  assign w_hs     = S_AXI_LITE_WVALID  && S_AXI_LITE_WREADY;
  assign ar_hs    = S_AXI_LITE_ARVALID && S_AXI_LITE_ARREADY;
  assign w_commit = (w_state == W_IDLE) && aw_have && w_have;
  assign aw_is_rw = aw_idx < IDXW'(C_NUM_REGS);

  assign ar_idx       = S_AXI_LITE_ARADDR[C_S_AXI_LITE_ADDR_WIDTH-1:2];
  assign ar_is_rw     = ar_idx < IDXW'(C_NUM_REGS);
  assign ar_is_status = ar_idx == IDXW'(C_NUM_REGS);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (ar_idx == IDXW'(i)) rd_mux = regs[i];
    end
    if (ar_is_status) rd_mux = STATUS_IN;
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[DW*g +: DW] = regs[g];
  end

  // Write channel: AW and W latch independently; the commit happens on the edge after both are held.
  always_ff @(posedge S_AXI_LITE_ACLK) begin
    if (!S_AXI_LITE_ARESETN) begin
      active            <= 1'b0;
      w_state           <= W_IDLE;
      aw_have           <= 1'b0;
      w_have            <= 1'b0;
      aw_idx            <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      S_AXI_LITE_BVALID <= 1'b0;
      S_AXI_LITE_BRESP  <= RESP_OKAY;
      REG_WR_PULSE      <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      active       <= 1'b1;
      REG_WR_PULSE <= '0;
      if (w_state == W_IDLE) begin
        if (aw_hs) begin
          aw_have <= 1'b1;
          aw_idx  <= S_AXI_LITE_AWADDR[C_S_AXI_LITE_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_have <= 1'b1;
          w_data <= S_AXI_LITE_WDATA;
          w_strb <= S_AXI_LITE_WSTRB;
        end
        if (w_commit) begin
          aw_have           <= 1'b0;
          w_have            <= 1'b0;
          S_AXI_LITE_BVALID <= 1'b1;
          S_AXI_LITE_BRESP  <= aw_is_rw ? RESP_OKAY : RESP_SLVERR;
          w_state           <= W_RESP;
          for (int i = 0; i < C_NUM_REGS; i++) begin
            if (aw_idx == IDXW'(i)) begin
              REG_WR_PULSE[i] <= 1'b1;
              for (int b = 0; b < NB; b++) begin
                if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
          end
        end
      end else if (S_AXI_LITE_BREADY) begin
        S_AXI_LITE_BVALID <= 1'b0;
        w_state           <= W_IDLE;
      end
    end
  end

  // Read data is captured from the pre-commit register value when a write lands on the same edge.
  always_ff @(posedge S_AXI_LITE_ACLK) begin
    if (!S_AXI_LITE_ARESETN) begin
      r_state           <= R_IDLE;
      S_AXI_LITE_RVALID <= 1'b0;
      S_AXI_LITE_RRESP  <= RESP_OKAY;
      S_AXI_LITE_RDATA  <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        S_AXI_LITE_RVALID <= 1'b1;
        S_AXI_LITE_RDATA  <= rd_mux;
        S_AXI_LITE_RRESP  <= (ar_is_rw || ar_is_status) ? RESP_OKAY : RESP_SLVERR;
        r_state           <= R_RESP;
      end
    end else if (S_AXI_LITE_RREADY) begin
      S_AXI_LITE_RVALID <= 1'b0;
      r_state           <= R_IDLE;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// Directed bench for axi4_lite_slave_regbank: inputs driven and outputs sampled on the falling edge.
module tb_axi4_lite_slave_regbank;

  logic         clk = 1'b0;
  logic         resetn;
  logic [31:0]  awaddr, araddr, wdata, rdata, status;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [255:0] reg_out;
  logic [7:0]   pulse;
  logic [255:0] exp_regs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_regbank dut (
    .S_AXI_LITE_ACLK    (clk),
    .S_AXI_LITE_ARESETN (resetn),
    .S_AXI_LITE_AWADDR  (awaddr),
    .S_AXI_LITE_AWPROT  (awprot),
    .S_AXI_LITE_AWVALID (awvalid),
    .S_AXI_LITE_AWREADY (awready),
    .S_AXI_LITE_WDATA   (wdata),
    .S_AXI_LITE_WSTRB   (wstrb),
    .S_AXI_LITE_WVALID  (wvalid),
    .S_AXI_LITE_WREADY  (wready),
    .S_AXI_LITE_BRESP   (bresp),
    .S_AXI_LITE_BVALID  (bvalid),
    .S_AXI_LITE_BREADY  (bready),
    .S_AXI_LITE_ARADDR  (araddr),
    .S_AXI_LITE_ARPROT  (arprot),
    .S_AXI_LITE_ARVALID (arvalid),
    .S_AXI_LITE_ARREADY (arready),
    .S_AXI_LITE_RDATA   (rdata),
    .S_AXI_LITE_RRESP   (rresp),
    .S_AXI_LITE_RVALID  (rvalid),
    .S_AXI_LITE_RREADY  (rready),
    .REG_OUT            (reg_out),
    .REG_WR_PULSE       (pulse),
    .STATUS_IN          (status)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; awaddr = '0; araddr = '0; wdata = '0; status = '0;
    awprot = 3'b0; arprot = 3'b0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    exp_regs = '0;

    // Reset state and ready release
    step(); step();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_pulse", pulse, 0);
    resetn = 1'b1;
    step();
    chk("rel_readies", {awready, wready, arready}, 3'b111);

    // AW and W in the same cycle to 0x04
    awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1;
    step();
    awvalid = 0; wvalid = 0;
    chk("t1_bvalid_early", bvalid, 0);
    chk("t1_readies_low", {awready, wready}, 2'b00);
    step();
    exp_regs[63:32] = 32'hDEADBEEF;
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_reg_out", reg_out, exp_regs);
    chk("t1_pulse", pulse, 8'h02);
    step();
    chk("t1_pulse_clr", pulse, 8'h00);
    chk("t1_bvalid_clr", bvalid, 0);
    chk("t1_awready_back", awready, 1);

    // W three cycles ahead of AW, partial strobe
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5;
    step();
    wvalid = 0;
    chk("t2_wready_low", wready, 0);
    chk("t2_awready_high", awready, 1);
    step(); step();
    chk("t2_wready_still_low", wready, 0);
    awvalid = 1; awaddr = 32'h00;
    step();
    awvalid = 0;
    chk("t2_bvalid_early", bvalid, 0);
    step();
    exp_regs[31:0] = 32'h00220044;
    chk("t2_bvalid", bvalid, 1);
    chk("t2_bresp", bresp, 2'b00);
    chk("t2_reg_out", reg_out, exp_regs);
    chk("t2_pulse", pulse, 8'h01);
    step();
    chk("t2_bvalid_clr", bvalid, 0);

    // Read 0x04 with RREADY held low for 5 cycles
    arvalid = 1; araddr = 32'h04; rready = 0;
    step();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold_rvalid_%0d", i), rvalid, 1);
      chk($sformatf("t3_hold_rdata_%0d", i), rdata, 32'hDEADBEEF);
      chk($sformatf("t3_hold_arready_%0d", i), arready, 0);
      if (i < 4) step();
    end
    rready = 1;
    step();
    chk("t3_rvalid_clr", rvalid, 0);
    chk("t3_arready_back", arready, 1);

    // Status word read; later STATUS_IN change must not disturb held data
    status = 32'hA5A5A5A5; arvalid = 1; araddr = 32'h20; rready = 0;
    step();
    arvalid = 0; status = 32'h12345678;
    chk("t3s_rvalid", rvalid, 1);
    chk("t3s_rdata", rdata, 32'hA5A5A5A5);
    chk("t3s_rresp", rresp, 2'b00);
    step();
    chk("t3s_rdata_held", rdata, 32'hA5A5A5A5);
    rready = 1;
    step();
    chk("t3s_rvalid_clr", rvalid, 0);

    // Writes to status and unmapped addresses
    awvalid = 1; awaddr = 32'h20; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; bready = 0;
    step();
    awvalid = 0; wvalid = 0;
    step();
    chk("t4a_bvalid", bvalid, 1);
    chk("t4a_bresp", bresp, 2'b10);
    chk("t4a_pulse", pulse, 8'h00);
    chk("t4a_reg_out", reg_out, exp_regs);
    bready = 1;
    step();
    awvalid = 1; awaddr = 32'h40; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    step();
    chk("t4b_bresp", bresp, 2'b10);
    chk("t4b_pulse", pulse, 8'h00);
    chk("t4b_reg_out", reg_out, exp_regs);
    step();
    arvalid = 1; araddr = 32'h40; rready = 0;
    step();
    arvalid = 0;
    chk("t4c_rdata", rdata, 32'h0);
    chk("t4c_rresp", rresp, 2'b10);
    rready = 1;
    step();

    // Read captured on the same edge as a write commit to the same register
    awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'h3; wstrb = 4'hF; bready = 1;
    step();
    awvalid = 0; wvalid = 0;
    step(); step();
    awvalid = 1; wvalid = 1; wdata = 32'h5; bready = 0;
    step();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h08; rready = 0;
    step();
    arvalid = 0;
    exp_regs[95:64] = 32'h5;
    chk("t5_rdata_old", rdata, 32'h3);
    chk("t5_bvalid", bvalid, 1);
    chk("t5_reg_out", reg_out, exp_regs);
    bready = 1; rready = 1;
    step();
    arvalid = 1;
    step();
    arvalid = 0;
    chk("t5_rdata_new", rdata, 32'h5);
    step();

    // Reset while both responses are pending
    bready = 0; rready = 0;
    awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'h77; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h00;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    chk("t6_pre_valids", {bvalid, rvalid}, 2'b11);
    resetn = 0;
    step();
    chk("t6_valids", {bvalid, rvalid}, 2'b00);
    chk("t6_reg_out", reg_out, 0);
    chk("t6_pulse", pulse, 0);
    chk("t6_readies_low", {awready, wready, arready}, 3'b000);
    resetn = 1;
    step();
    chk("t6_readies_high", {awready, wready, arready}, 3'b111);
    chk("t6_valids_after", {bvalid, rvalid}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
